// File: rtl/fetch_stage.sv
// fetch_stage: IF stage of the RV32 pipeline. Owns the PC, issues in-order fetches on a
// req/gnt/rvalid port and queues returned words for the IF/ID register.
// Ports: clk_i, rst_ni (async, active-low); pc_enable_i / id_enable_i (stall / accept);
//        br_sel_i, br_target_i (redirect + flush); imem_req_o, imem_addr_o, imem_gnt_i,
//        imem_rvalid_i, imem_rdata_i (fetch port); if_valid_o, if_pc_o, if_instr_o,
//        if_misaligned_o (head entry).
// Option: define FETCH_MISALIGN_EN to turn a misaligned redirect into a marker entry + halt.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        pc_enable_i,
    input  logic        id_enable_i,
    input  logic        br_sel_i,
    input  logic [31:0] br_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_instr_o,
    output logic        if_misaligned_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [31:0]   NOP = 32'h0000_0013;
    localparam logic [AW-1:0] P1  = AW'(1);
    localparam logic [CW-1:0] C1  = CW'(1);
    localparam logic [CW-1:0] LIM = CW'(DEPTH);

    logic [31:0]    pc_q;
    logic [AW-1:0]  wr_ptr, fill_ptr, rd_ptr;
    logic [CW-1:0]  occ_cnt, pend_cnt, drop_cnt;
    logic [31:0]    q_pc    [DEPTH];
    logic [31:0]    q_instr [DEPTH];
    logic [DEPTH-1:0] q_filled;

    logic           halt;
    logic           mis_flush;
    logic [31:0]    tgt;
    logic           head_valid;
    logic           grant, fill, drop_rv, pop;
    logic [CW-1:0]  drop_flush;

    // Redirect targets are word-aligned unless the marker path takes over.
    assign tgt = br_target_i & ~32'h3;

    assign head_valid = (occ_cnt != '0) & q_filled[rd_ptr];

    // Dropped-but-outstanding responses still hold a slot of the budget.
    assign imem_req_o = rst_ni & pc_enable_i & ~br_sel_i & ~halt
                      & ((occ_cnt + drop_cnt) < LIM);
    assign imem_addr_o = pc_q;

    assign grant   = imem_req_o & imem_gnt_i;
    assign drop_rv = imem_rvalid_i & (drop_cnt != '0);
    assign fill    = imem_rvalid_i & (drop_cnt == '0) & (pend_cnt != '0);
    assign pop     = head_valid & id_enable_i;

    // On flush every unfilled entry becomes a response to discard; one that
    // arrives in the flush cycle itself is already consumed.
    always_comb begin
        drop_flush = drop_cnt + pend_cnt;
        if (imem_rvalid_i && drop_flush != '0)
            drop_flush = drop_flush - C1;
    end

`ifdef FETCH_MISALIGN_EN
    logic [DEPTH-1:0] q_mis;
    logic             halt_q;

    assign mis_flush = br_sel_i & (br_target_i[1:0] != 2'b00);
    assign halt      = halt_q;
    assign if_misaligned_o = head_valid & q_mis[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            halt_q <= 1'b0;
            q_mis  <= '0;
        end else if (br_sel_i) begin
            halt_q <= mis_flush;
            q_mis  <= mis_flush ? DEPTH'(1) : '0;
        end else if (grant) begin
            q_mis[wr_ptr] <= 1'b0;
        end
    end
`else
    assign mis_flush       = 1'b0;
    assign halt            = 1'b0;
    assign if_misaligned_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q     <= RESET_PC;
            wr_ptr   <= '0;
            fill_ptr <= '0;
            rd_ptr   <= '0;
            occ_cnt  <= '0;
            pend_cnt <= '0;
            drop_cnt <= '0;
            q_filled <= '0;
        end else if (br_sel_i) begin
            pc_q     <= tgt;
            rd_ptr   <= '0;
            pend_cnt <= '0;
            drop_cnt <= drop_flush;
            if (mis_flush) begin
                // Marker entry sits at slot 0, already filled.
                wr_ptr   <= P1;
                fill_ptr <= P1;
                occ_cnt  <= C1;
                q_filled <= DEPTH'(1);
            end else begin
                wr_ptr   <= '0;
                fill_ptr <= '0;
                occ_cnt  <= '0;
                q_filled <= '0;
            end
        end else begin
            if (grant) begin
                pc_q             <= pc_q + 32'd4;
                wr_ptr           <= wr_ptr + P1;
                q_filled[wr_ptr] <= 1'b0;
            end
            if (fill) begin
                fill_ptr           <= fill_ptr + P1;
                q_filled[fill_ptr] <= 1'b1;
            end
            if (drop_rv)
                drop_cnt <= drop_cnt - C1;
            if (pop)
                rd_ptr <= rd_ptr + P1;
            occ_cnt  <= occ_cnt + CW'(grant) - CW'(pop);
            pend_cnt <= pend_cnt + CW'(grant) - CW'(fill);
        end
    end

    // Payload storage needs no reset: q_filled/occ_cnt gate every read.
    always_ff @(posedge clk_i) begin
        if (br_sel_i) begin
            if (mis_flush) begin
                q_pc[0]    <= br_target_i;
                q_instr[0] <= NOP;
            end
        end else begin
            if (grant)
                q_pc[wr_ptr] <= pc_q;
            if (fill)
                q_instr[fill_ptr] <= imem_rdata_i;
        end
    end

    assign if_valid_o = head_valid;
    assign if_pc_o    = head_valid ? q_pc[rd_ptr] : 32'h0;
    assign if_instr_o = head_valid ? q_instr[rd_ptr] : NOP;

endmodule
